// File: rtl/seg_bin2digits.sv
// seg_bin2digits: binary-to-seven-segment front end for the multiplexed display driver.
// Accepts a value over valid/ready, converts it with a one-shift-per-clock double-dabble
// engine, then registers per-digit active-high segment bytes and a digit-valid mask.
// Optional leading-zero blanking: define SEG_BIN2DIGITS_LZB_EN.
module seg_bin2digits #(
  parameter int NDigits = 8,
  parameter int WIDTH   = 27
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       value_i,
  input  logic [NDigits-1:0]     dp_i,
  output logic [NDigits*8-1:0]   seg_o,
  output logic [NDigits-1:0]     digit_valid_o,
  output logic                   ovf_o,
  output logic                   done_o
);

  localparam int BW = 4 * NDigits;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_LOAD
  } state_t;

  state_t                r_state;
  logic [WIDTH-1:0]      r_bin;
  logic [BW-1:0]         r_bcd;
  logic [CW-1:0]         r_cnt;
  logic                  r_ovf_sticky;
  logic [NDigits-1:0]    r_dp;
  logic [NDigits*8-1:0]  r_seg;
  logic [NDigits-1:0]    r_dv;
  logic                  r_ovf;
  logic                  r_done;

  logic [BW-1:0]         w_bcd_adj;
  logic [BW+WIDTH-1:0]   w_shift;
  logic [NDigits*8-1:0]  w_seg_nxt;
  logic [NDigits-1:0]    w_dv_nxt;
`ifdef SEG_BIN2DIGITS_LZB_EN
  logic [NDigits-1:0]    w_lead;
`endif

  function automatic logic [6:0] enc7(input logic [3:0] d);
    case (d)
      4'd0:    enc7 = 7'h3F;
      4'd1:    enc7 = 7'h06;
      4'd2:    enc7 = 7'h5B;
      4'd3:    enc7 = 7'h4F;
      4'd4:    enc7 = 7'h66;
      4'd5:    enc7 = 7'h6D;
      4'd6:    enc7 = 7'h7D;
      4'd7:    enc7 = 7'h07;
      4'd8:    enc7 = 7'h7F;
      4'd9:    enc7 = 7'h6F;
      default: enc7 = 7'h00;
    endcase
  endfunction

  // Add-3 correction on every nibble, all from the pre-adjust values.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int unsigned k = 0; k < NDigits; k++) begin
      if (r_bcd[k*4 +: 4] >= 4'd5) begin
        w_bcd_adj[k*4 +: 4] = r_bcd[k*4 +: 4] + 4'd3;
      end
    end
  end

  // Top BCD bit drops off here; it is captured separately as the overflow indication.
  assign w_shift = {w_bcd_adj[BW-2:0], r_bin, 1'b0};

`ifdef SEG_BIN2DIGITS_LZB_EN
  // Digit i (i>0) is a leading zero when it and every digit above it are zero.
  always_comb begin
    w_lead = '0;
    for (int unsigned i = 1; i < NDigits; i++) begin
      w_lead[i] = 1'b1;
      for (int unsigned j = i; j < NDigits; j++) begin
        if (r_bcd[j*4 +: 4] != 4'd0) begin
          w_lead[i] = 1'b0;
        end
      end
    end
  end
`endif

  // Segment bytes and valid mask for the finished conversion; overflow wins over blanking.
  always_comb begin
    w_seg_nxt = '0;
    w_dv_nxt  = '1;
    for (int unsigned i = 0; i < NDigits; i++) begin
      if (r_ovf_sticky) begin
        w_seg_nxt[i*8 +: 8] = 8'h40;
      end else begin
        w_seg_nxt[i*8 +: 8] = {r_dp[i], enc7(r_bcd[i*4 +: 4])};
`ifdef SEG_BIN2DIGITS_LZB_EN
        if (w_lead[i]) begin
          if (r_dp[i]) begin
            w_seg_nxt[i*8 +: 8] = 8'h80;
          end else begin
            w_seg_nxt[i*8 +: 8] = 8'h00;
            w_dv_nxt[i]         = 1'b0;
          end
        end
`endif
      end
    end
  end

  // Control FSM, conversion datapath and registered display outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_bin        <= '0;
      r_bcd        <= '0;
      r_cnt        <= '0;
      r_ovf_sticky <= 1'b0;
      r_dp         <= '0;
      r_seg        <= '0;
      r_dv         <= '0;
      r_ovf        <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_bin        <= value_i;
            r_dp         <= dp_i;
            r_bcd        <= '0;
            r_cnt        <= '0;
            r_ovf_sticky <= 1'b0;
            r_state      <= S_CONV;
          end
        end
        S_CONV: begin
          r_bcd <= w_shift[BW+WIDTH-1:WIDTH];
          r_bin <= w_shift[WIDTH-1:0];
          if (w_bcd_adj[BW-1]) begin
            r_ovf_sticky <= 1'b1;
          end
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_seg   <= w_seg_nxt;
          r_dv    <= w_dv_nxt;
          r_ovf   <= r_ovf_sticky;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = (r_state == S_IDLE);
  assign seg_o         = r_seg;
  assign digit_valid_o = r_dv;
  assign ovf_o         = r_ovf;
  assign done_o        = r_done;

endmodule

// File: tb/tb_seg_bin2digits.sv
// Self-checking bench for seg_bin2digits: decimal reference model feeding a scoreboard queue,
// compared on every done_o pulse. Honors SEG_BIN2DIGITS_LZB_EN in the reference model.
module tb_seg_bin2digits;

  localparam int ND = 8;
  localparam int W  = 27;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [W-1:0]      value_i = '0;
  logic [ND-1:0]     dp_i = '0;
  logic [ND*8-1:0]   seg_o;
  logic [ND-1:0]     digit_valid_o;
  logic              ovf_o;
  logic              done_o;

  seg_bin2digits #(.NDigits(ND), .WIDTH(W)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .value_i       (value_i),
    .dp_i          (dp_i),
    .seg_o         (seg_o),
    .digit_valid_o (digit_valid_o),
    .ovf_o         (ovf_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ND*8-1:0] seg;
    logic [ND-1:0]   dv;
    logic            ovf;
    int              acc;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      default: return 7'h6F;
    endcase
  endfunction

  function automatic exp_t model(input longint v, input logic [ND-1:0] dp, input int acc);
    exp_t   e;
    longint p;
    int     dig[ND];
    int     msd;
    e.acc = acc;
    e.dv  = '1;
    e.seg = '0;
    if (v >= 64'd100000000) begin
      e.ovf = 1'b1;
      for (int i = 0; i < ND; i++) e.seg[i*8 +: 8] = 8'h40;
    end else begin
      e.ovf = 1'b0;
      p   = v;
      msd = 0;
      for (int i = 0; i < ND; i++) begin
        dig[i] = int'(p % 10);
        p      = p / 10;
        if (dig[i] != 0) msd = i;
      end
      for (int i = 0; i < ND; i++) begin
        e.seg[i*8 +: 8] = {dp[i], seg7(dig[i])};
`ifdef SEG_BIN2DIGITS_LZB_EN
        if (i > msd) begin
          if (dp[i]) e.seg[i*8 +: 8] = 8'h80;
          else begin
            e.seg[i*8 +: 8] = 8'h00;
            e.dv[i]         = 1'b0;
          end
        end
`endif
      end
    end
    return e;
  endfunction

  // Scoreboard compare on each output update.
  always @(negedge clk) begin
    if (done_o) begin
      done_cnt++;
      if (q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        m_e = q.pop_front();
        chk("seg", seg_o, m_e.seg);
        chk("dv", digit_valid_o, m_e.dv);
        chk("ovf", ovf_o, m_e.ovf);
        chk("latency", cyc - m_e.acc, W + 1);
      end
    end
  end

  task automatic send(input longint v, input logic [ND-1:0] dp, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("ready_timeout", 0, 1);
    value_i  = W'(v);
    dp_i     = dp;
    in_valid = 1'b1;
    if (push) q.push_back(model(v, dp, cyc + 1));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 0, 1);
      q.delete();
    end
    @(negedge clk);
  endtask

  longint          tv[6]  = '{5, 10, 100000, 9, 134217727, 1000};
  logic [ND-1:0]   tdp[6] = '{8'h04, 8'h00, 8'h81, 8'h01, 8'h00, 8'hF0};
  int              busy;
  int              n;
  int              base;
  bit              held;
  logic [ND*8-1:0] s8;

  initial begin
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_seg", seg_o, 0);
    chk("rst_dv", digit_valid_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ready", in_ready, 1);
    rstn = 1'b1;

    send(0, 8'h00, 1'b1);
    drain();

    send(12345678, 8'h10, 1'b1);
    drain();
    chk("t2_const", seg_o, 64'h065B4FE66D7D077F);

    send(99999999, 8'h00, 1'b1);
    send(100000000, 8'hFF, 1'b1);
    drain();
    chk("t3_ovf", ovf_o, 1);

    for (int i = 0; i < 6; i++) send(tv[i], tdp[i], 1'b1);
    for (int i = 0; i < 6; i++) send(longint'($urandom_range(0, 134217727)), ND'($urandom), 1'b1);
    drain();

    // Hold in_valid with a new value through the whole busy window.
    @(negedge clk);
    value_i  = W'(42);
    dp_i     = '0;
    in_valid = 1'b1;
    q.push_back(model(42, 8'h00, cyc + 1));
    @(posedge clk);
    #1 value_i = W'(7);
    busy = 0;
    n    = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      busy++;
      @(negedge clk);
      n++;
    end
    chk("t4_busy", busy, W + 1);
    q.push_back(model(7, 8'h00, cyc + 1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    // Outputs must hold the previous display during conversion.
    send(8, 8'h00, 1'b1);
    drain();
    m_e  = model(8, 8'h00, 0);
    s8   = m_e.seg;
    send(9, 8'h00, 1'b1);
    held = 1'b1;
    n    = 0;
    while (!done_o && n < 100) begin
      if (seg_o !== s8) held = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("t6_hold", held, 1);
    chk("t6_done_seen", done_o, 1);
    drain();

    // Reset mid-conversion aborts and produces no later update.
    send(555, 8'h00, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_seg", seg_o, 0);
    chk("t5_dv", digit_valid_o, 0);
    chk("t5_ovf", ovf_o, 0);
    chk("t5_done", done_o, 0);
    chk("t5_ready", in_ready, 1);
    @(negedge clk);
    rstn = 1'b1;
    base = done_cnt;
    repeat (40) @(negedge clk);
    chk("t5_no_done", done_cnt - base, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
